phv_writeback: RTL

Writeback stage of an RMT action stage: takes the per-container ALU results for the 64 4-byte PHV containers and merges them with the original PHV under control of each container's action opcode. The reassembled PHV goes to the next stage through a 2-entry output buffer with valid/ready handshake. Sits after the ALU array and is the receiving end of the crossbar → ALU data path.

---
 rtl/phv_writeback.sv | 126 ++++++++++++
 1 files changed

// File: rtl/phv_writeback.sv
// ---------------------------------------------------------------------------
// phv_writeback
//
// Writeback stage of an RMT action stage. Each of the 64 4-byte PHV
// containers is taken either from the ALU result or from the original PHV,
// depending on that container's action opcode. Metadata [255:0] always comes
// from the original PHV. Merged PHVs are queued in a 2-entry output buffer.
//
// Handshake semantics (both sides):
//   A transfer happens at a rising edge where valid && ready are both high.
//   Upstream : alu_out_valid / ready_out   (ready_out is registered)
//   Downstream: phv_out_valid / ready_in   (phv_out is the buffer head and is
//   held stable while phv_out_valid && !ready_in)
//   ready_out never depends combinationally on ready_in.
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   alu_out_valid in   ALU results, original PHV and action bundle are valid
//   alu_out_4B    in   64 ALU results, container i at [32i+31:32i]
//   phv_orig      in   original PHV, container i at [256+32i+31:256+32i]
//   action_in     in   action bundle, word k at [64k+63:64k], word 0 unused
//   ready_out     out  block accepts input this cycle
//   phv_out       out  reassembled PHV at the buffer head
//   phv_out_valid out  phv_out holds a PHV
//   ready_in      in   downstream accepts phv_out
//   phv_count     out  number of PHVs delivered downstream (wraps)
// ---------------------------------------------------------------------------
module phv_writeback #(
  parameter int STAGE_ID   = 0,
  parameter int PHV_LEN    = 4*8*64+256,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int width_4B   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_out_valid,
  input  logic [width_4B*64-1:0]        alu_out_4B,
  input  logic [PHV_LEN-1:0]            phv_orig,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
  output logic                          ready_out,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_out_valid,
  input  logic                          ready_in,
  output logic [31:0]                   phv_count
);

  // Opcodes whose ALU result replaces the container.
  function automatic logic is_write_op(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h07, 8'h08,
      8'h09, 8'h0A, 8'h0B, 8'h0E: is_write_op = 1'b1;
      default:                    is_write_op = 1'b0;
    endcase
  endfunction

  logic [PHV_LEN-1:0] w_merged;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_count_nxt;
  logic               w_unused_act;

  logic [PHV_LEN-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               r_ready_out;
  logic [31:0]        r_phv_count;

  // Only the opcode byte of words 1..64 is consumed.
  assign w_unused_act = ^action_in;

  // Container merge; metadata passes through from phv_orig untouched.
  always_comb begin
    w_merged = phv_orig;
    for (int i = 0; i < 64; i++) begin
      if (is_write_op(action_in[ACT_LEN*(i+1)+56 +: 8])) begin
        w_merged[256+width_4B*i +: width_4B] = alu_out_4B[width_4B*i +: width_4B];
      end
    end
  end

  assign w_push = alu_out_valid && r_ready_out;
  assign w_pop  = (r_count != 2'd0) && ready_in;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Two-slot ring. On a simultaneous push/pop at count 1 the read pointer
  // moves onto the slot being written, so the new entry becomes head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_ready_out <= 1'b1;
      r_phv_count <= 32'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_merged;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr    <= ~r_rd_ptr;
        r_phv_count <= r_phv_count + 32'd1;
      end
      r_count     <= w_count_nxt;
      r_ready_out <= (w_count_nxt < 2'd2);
    end
  end

  assign ready_out     = r_ready_out;
  assign phv_out       = r_mem[r_rd_ptr];
  assign phv_out_valid = (r_count != 2'd0);
  assign phv_count     = r_phv_count;

endmodule
